// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the remote (master) end of the UART bus bridge.
//   - Default widths and the request frame layout {mode, wdata, addr}.
//   - Field offsets within a frame (addr at the bottom, mode at the top).
//   - Transfer mode encodings and the FSM state encoding.
//   - ERR_BYTE: reply byte used when a read never completes (timeout build).
// No ports (package).
// -----------------------------------------------------------------------------
package bridge_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 12;

   // Frame layout for the default widths: [MODE_BIT] mode, wdata above addr.
   localparam int FRAME_W   = DATA_WIDTH_DEF + ADDR_WIDTH_DEF + 1;
   localparam int ADDR_LSB  = 0;
   localparam int WDATA_LSB = ADDR_LSB + ADDR_WIDTH_DEF;
   localparam int MODE_BIT  = WDATA_LSB + DATA_WIDTH_DEF;

   localparam logic MODE_WRITE = 1'b1;
   localparam logic MODE_READ  = 1'b0;

   localparam logic [DATA_WIDTH_DEF-1:0] ERR_BYTE = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RWAIT  = 2'd2,
      ST_TXSEND = 2'd3
   } bridge_state_t;

   // Frame width for arbitrary parameterisations of the bridge.
   function automatic int frame_w(input int dw, input int aw);
      return dw + aw + 1;
   endfunction

endpackage

// File: rtl/bridge_req_fifo.sv
// -----------------------------------------------------------------------------
// bridge_req_fifo
// Synchronous FIFO holding received request frames until the master FSM
// replays them on the local bus. Show-ahead: o_data always presents the head
// entry so the FSM can register the fields in the same cycle it pops.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   i_push     write i_data (caller only pushes when not full or popping)
//   i_data     frame to store
//   i_pop      discard head entry (caller only pops when not empty)
//   o_data     head entry
//   o_full     count == DEPTH
//   o_empty    count == 0
//   o_count    number of stored entries, $clog2(DEPTH+1) bits
// -----------------------------------------------------------------------------
module bridge_req_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int L_PTR_W = $clog2(DEPTH);
   localparam int L_CNT_W = $clog2(DEPTH+1);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("bridge_req_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [L_PTR_W-1:0] r_wr_ptr;
   logic [L_PTR_W-1:0] r_rd_ptr;
   logic [L_CNT_W-1:0] r_count;

   // Storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + L_PTR_W'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + L_PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + L_CNT_W'(1);
            2'b01:   r_count <= r_count - L_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == L_CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/bus_bridge_master.sv
// -----------------------------------------------------------------------------
// bus_bridge_master
// Remote end of the UART bus bridge. Buffers decoded request frames
// {mode, wdata, addr} in a small FIFO and replays them one at a time, in
// order, on the local master port. Read results go back to the UART TX.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   urx_valid    one-cycle pulse, urx_frame holds a received frame
//   urx_frame    [ADDR_WIDTH-1:0] addr, next DATA_WIDTH bits wdata, MSB mode
//   utx_data     read byte for the UART TX (held until the next read ends)
//   utx_en       one-cycle send strobe
//   utx_busy     UART TX busy (rises the cycle after utx_en)
//   m_req        local bus request, held with stable fields until m_ack
//   m_mode       1 = write, 0 = read
//   m_addr       request address
//   m_wdata      write data
//   m_ack        one-cycle pulse: request accepted
//   m_rvalid     one-cycle pulse: m_rdata valid (only looked at in RWAIT)
//   m_rdata      read data
//   frame_drop   sticky until reset: a frame was lost because the FIFO was full
//   bridge_idle  FIFO empty and FSM idle
//
// Build option BRIDGE_TIMEOUT_EN: when defined, a read that sees no m_rvalid
// for TIMEOUT_CYCLES cycles is answered with ERR_BYTE (all ones). When not
// defined, a read waits for m_rvalid indefinitely.
// -----------------------------------------------------------------------------
module bus_bridge_master
   import bridge_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           urx_valid,
   input  logic [DATA_WIDTH+ADDR_WIDTH:0] urx_frame,
   output logic [DATA_WIDTH-1:0]          utx_data,
   output logic                           utx_en,
   input  logic                           utx_busy,
   output logic                           m_req,
   output logic                           m_mode,
   output logic [ADDR_WIDTH-1:0]          m_addr,
   output logic [DATA_WIDTH-1:0]          m_wdata,
   input  logic                           m_ack,
   input  logic                           m_rvalid,
   input  logic [DATA_WIDTH-1:0]          m_rdata,
   output logic                           frame_drop,
   output logic                           bridge_idle
);

   localparam int L_FRAME_W   = frame_w(DATA_WIDTH, ADDR_WIDTH);
   localparam int L_WDATA_LSB = ADDR_LSB + ADDR_WIDTH;
   localparam int L_MODE_BIT  = L_WDATA_LSB + DATA_WIDTH;
   localparam int L_CNT_W     = $clog2(FIFO_DEPTH + 1);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("bus_bridge_master: TIMEOUT_CYCLES must be at least 1");
   end

   bridge_state_t          r_state;
   bridge_state_t          w_state_next;
   logic                   w_utx_en;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_timeout;
   logic [L_CNT_W-1:0]     w_count;
   logic [L_FRAME_W-1:0]   w_head;

   logic                   r_m_mode;
   logic [ADDR_WIDTH-1:0]  r_m_addr;
   logic [DATA_WIDTH-1:0]  r_m_wdata;
   logic [DATA_WIDTH-1:0]  r_utx_data;
   logic                   r_frame_drop;

   // The FSM takes the head whenever it is idle; a frame arriving while the
   // FIFO is full still fits if that pop happens in the same cycle.
   assign w_pop  = (r_state == ST_IDLE) && !w_empty;
   assign w_push = urx_valid && (!w_full || w_pop);

   bridge_req_fifo #(
      .WIDTH (L_FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (urx_frame),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

`ifdef BRIDGE_TIMEOUT_EN
   localparam int L_TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [L_TO_W-1:0] r_to_cnt;

   // Held at zero outside RWAIT, so every read starts a fresh count. The FSM
   // leaves RWAIT at the terminal value, so the counter never wraps.
   always_ff @(posedge clk) begin
      if (rst || (r_state != ST_RWAIT)) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + L_TO_W'(1);
      end
   end

   assign w_timeout = (r_state == ST_RWAIT) &&
                      (r_to_cnt == L_TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_utx_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (m_ack) begin
               w_state_next = (r_m_mode == MODE_WRITE) ? ST_IDLE : ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            if (m_rvalid || w_timeout) begin
               w_state_next = ST_TXSEND;
            end
         end
         ST_TXSEND: begin
            if (!utx_busy) begin
               w_utx_en     = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_mode     <= 1'b0;
         r_m_addr     <= '0;
         r_m_wdata    <= '0;
         r_utx_data   <= '0;
         r_frame_drop <= 1'b0;
      end else begin
         if (w_pop) begin
            r_m_mode  <= w_head[L_MODE_BIT];
            r_m_addr  <= w_head[L_WDATA_LSB-1:ADDR_LSB];
            r_m_wdata <= w_head[L_MODE_BIT-1:L_WDATA_LSB];
         end
         // Real read data takes priority over a timeout in the same cycle.
         if (r_state == ST_RWAIT) begin
            if (m_rvalid) begin
               r_utx_data <= m_rdata;
            end else if (w_timeout) begin
               r_utx_data <= '1;
            end
         end
         if (urx_valid && !w_push) begin
            r_frame_drop <= 1'b1;
         end
      end
   end

   assign m_req       = (r_state == ST_ISSUE);
   assign m_mode      = r_m_mode;
   assign m_addr      = r_m_addr;
   assign m_wdata     = r_m_wdata;
   assign utx_data    = r_utx_data;
   assign utx_en      = w_utx_en;
   assign frame_drop  = r_frame_drop;
   assign bridge_idle = (r_state == ST_IDLE) && (w_count == '0);

endmodule

// File: tb/tb_bus_bridge_master.sv
// -----------------------------------------------------------------------------
// tb_bus_bridge_master
// Directed bench for bus_bridge_master: reset state, write, read, overflow,
// full-with-simultaneous-pop, reset during a read, read timeout (or the
// indefinite wait when BRIDGE_TIMEOUT_EN is not defined) and a busy UART.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_bus_bridge_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        urx_valid;
   logic [20:0] urx_frame;
   logic [7:0]  utx_data;
   logic        utx_en;
   logic        utx_busy;
   logic        m_req;
   logic        m_mode;
   logic [11:0] m_addr;
   logic [7:0]  m_wdata;
   logic        m_ack;
   logic        m_rvalid;
   logic [7:0]  m_rdata;
   logic        frame_drop;
   logic        bridge_idle;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_tx     = 0;
   int          tx_before;
   logic [20:0] txn_q [$];

   always #5 clk = ~clk;

   bus_bridge_master #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (12),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .urx_valid   (urx_valid),
      .urx_frame   (urx_frame),
      .utx_data    (utx_data),
      .utx_en      (utx_en),
      .utx_busy    (utx_busy),
      .m_req       (m_req),
      .m_mode      (m_mode),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_ack       (m_ack),
      .m_rvalid    (m_rvalid),
      .m_rdata     (m_rdata),
      .frame_drop  (frame_drop),
      .bridge_idle (bridge_idle)
   );

   // Bus-side log: accepted requests and UART send strobes.
   always @(posedge clk) begin
      if (m_req && m_ack) begin
         txn_q.push_back({m_mode, m_wdata, m_addr});
         $display("[%0t] bus txn mode=%0d addr=0x%03h wdata=0x%02h", $time, m_mode, m_addr, m_wdata);
      end
      if (utx_en) begin
         n_tx++;
         $display("[%0t] uart send data=0x%02h", $time, utx_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before 500us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic mode, input logic [7:0] wd, input logic [11:0] ad);
      urx_valid = 1'b1;
      urx_frame = {mode, wd, ad};
      tick();
      urx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      m_ack     = 1'b0;
      m_rvalid  = 1'b0;
      urx_valid = 1'b0;
      utx_busy  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (m_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic serve_write();
      bit ok;
      wait_req(ok);
      check("req_seen", ok, 1);
      tick();
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
   endtask

   initial begin
      bit          ok;
      logic [20:0] exp_f;

      rst       = 1'b1;
      urx_valid = 1'b0;
      urx_frame = '0;
      utx_busy  = 1'b0;
      m_ack     = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      repeat (3) tick();

      // ---- reset state
      @(negedge clk);
      check("rst_m_req", m_req, 0);
      check("rst_utx_en", utx_en, 0);
      check("rst_utx_data", utx_data, 0);
      check("rst_m_mode", m_mode, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_wdata", m_wdata, 0);
      check("rst_frame_drop", frame_drop, 0);
      check("rst_idle", bridge_idle, 1);
      tick();
      rst = 1'b0;

      // ---- write {1, A5, 123}, ack two cycles after m_req
      send_frame(1'b1, 8'hA5, 12'h123);
      @(negedge clk);
      check("wr_req_before_pop", m_req, 0);
      tick();
      @(negedge clk);
      check("wr_req", m_req, 1);
      check("wr_mode", m_mode, 1);
      check("wr_addr", m_addr, 12'h123);
      check("wr_wdata", m_wdata, 8'hA5);
      tick();
      tick();
      m_ack = 1'b1;
      @(negedge clk);
      check("wr_req_held", m_req, 1);
      tick();
      m_ack = 1'b0;
      @(negedge clk);
      check("wr_req_drop", m_req, 0);
      check("wr_idle", bridge_idle, 1);
      repeat (5) tick();
      check("wr_no_uart", n_tx, 0);

      // ---- read {0, 00, 456}; rvalid in the ack cycle must be ignored
      tx_before = n_tx;
      send_frame(1'b0, 8'h00, 12'h456);
      tick();
      @(negedge clk);
      check("rd_req", m_req, 1);
      check("rd_mode", m_mode, 0);
      check("rd_addr", m_addr, 12'h456);
      tick();
      m_ack    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 8'h99;
      tick();
      m_ack    = 1'b0;
      m_rvalid = 1'b0;
      tick();
      tick();
      m_rvalid = 1'b1;
      m_rdata  = 8'h3C;
      @(negedge clk);
      check("rd_en_rvalid_cycle", utx_en, 0);
      tick();
      m_rvalid = 1'b0;
      @(negedge clk);
      check("rd_en", utx_en, 1);
      check("rd_data", utx_data, 8'h3C);
      tick();
      @(negedge clk);
      check("rd_en_pulse_end", utx_en, 0);
      repeat (4) tick();
      check("rd_one_send", n_tx - tx_before, 1);
      check("rd_data_held", utx_data, 8'h3C);

      // ---- overflow: ack held low, 6 frames
      do_reset();
      txn_q.delete();
      for (int i = 0; i < 5; i++) begin
         send_frame(1'b1, 8'h10 + 8'(i), 12'h200 + 12'(i));
      end
      @(negedge clk);
      check("ovf_count_full", dut.u_fifo.o_count, 4);
      check("ovf_no_drop_yet", frame_drop, 0);
      send_frame(1'b1, 8'h15, 12'h205);
      @(negedge clk);
      check("ovf_drop", frame_drop, 1);
      check("ovf_count", dut.u_fifo.o_count, 4);
      check("ovf_head_addr", m_addr, 12'h200);
      for (int i = 0; i < 5; i++) begin
         serve_write();
      end
      repeat (3) tick();
      check("ovf_txn_count", txn_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         exp_f = {1'b1, 8'h10 + 8'(i), 12'h200 + 12'(i)};
         if (i < txn_q.size()) begin
            check($sformatf("ovf_txn%0d", i), txn_q[i], exp_f);
         end
      end
      check("ovf_drop_sticky", frame_drop, 1);
      check("ovf_idle", bridge_idle, 1);

      // ---- full FIFO, push coincides with IDLE pop
      do_reset();
      txn_q.delete();
      for (int i = 0; i < 5; i++) begin
         send_frame(1'b1, 8'h40 + 8'(i), 12'h300 + 12'(i));
      end
      wait_req(ok);
      check("fp_req_seen", ok, 1);
      tick();
      m_ack = 1'b1;
      tick();
      m_ack     = 1'b0;
      urx_valid = 1'b1;
      urx_frame = {1'b1, 8'h45, 12'h305};
      @(negedge clk);
      check("fp_count_pre", dut.u_fifo.o_count, 4);
      tick();
      urx_valid = 1'b0;
      @(negedge clk);
      check("fp_count_post", dut.u_fifo.o_count, 4);
      check("fp_no_drop", frame_drop, 0);
      for (int i = 0; i < 5; i++) begin
         serve_write();
      end
      repeat (3) tick();
      check("fp_txn_count", txn_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         exp_f = {1'b1, 8'h40 + 8'(i), 12'h300 + 12'(i)};
         if (i < txn_q.size()) begin
            check($sformatf("fp_txn%0d", i), txn_q[i], exp_f);
         end
      end

      // ---- reset while waiting for read data
      do_reset();
      tx_before = n_tx;
      send_frame(1'b0, 8'h00, 12'h7AB);
      wait_req(ok);
      check("rr_req_seen", ok, 1);
      tick();
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("rr_busy_before", bridge_idle, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rr_m_req", m_req, 0);
      check("rr_utx_en", utx_en, 0);
      check("rr_idle", bridge_idle, 1);
      tick();
      m_rvalid = 1'b1;
      m_rdata  = 8'h77;
      tick();
      m_rvalid = 1'b0;
      repeat (4) tick();
      check("rr_no_send", n_tx - tx_before, 0);
      check("rr_utx_data", utx_data, 0);

      // ---- read without m_rvalid
      tx_before = n_tx;
      send_frame(1'b0, 8'h00, 12'h0F0);
      wait_req(ok);
      check("to_req_seen", ok, 1);
      tick();
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      repeat (15) tick();
      @(negedge clk);
      check("to_en_early", utx_en, 0);
      tick();
      @(negedge clk);
      check("to_en", utx_en, 1);
      check("to_data", utx_data, 8'hFF);
      tick();
      @(negedge clk);
      check("to_en_end", utx_en, 0);
      check("to_idle", bridge_idle, 1);
      check("to_one_send", n_tx - tx_before, 1);
`else
      repeat (40) tick();
      @(negedge clk);
      check("nto_no_send", n_tx - tx_before, 0);
      check("nto_still_busy", bridge_idle, 0);
      // finish the read with the UART busy for two cycles
      tick();
      utx_busy = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 8'h5A;
      tick();
      m_rvalid = 1'b0;
      @(negedge clk);
      check("busy_en_held", utx_en, 0);
      tick();
      utx_busy = 1'b0;
      @(negedge clk);
      check("busy_en", utx_en, 1);
      check("busy_data", utx_data, 8'h5A);
      tick();
      @(negedge clk);
      check("busy_en_end", utx_en, 0);
      check("busy_one_send", n_tx - tx_before, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
